seq_mul8: RTL and testbench
===========================

Name: seq_mul8

Overview:
- Multi-cycle unsigned shift-add multiplier for the CPU datapath's MUL operation.
- Each cycle it steps an 8-bit ripple-carry add of the multiplicand into the running partial product, then shifts right one bit.
- It consumes the 8-bit adder's sum plus carry-out and produces a registered 16-bit product for the register-file writeback stage.
- A start/busy/done handshake is used toward the control unit.

Parameters:
- WIDTH, 8, operand width. Product is 2*WIDTH bits. Iteration count equals WIDTH.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply. Sampled only in IDLE or DONE.
- a  input  WIDTH  multiplicand, captured when start is accepted
- b  input  WIDTH  multiplier, captured when start is accepted
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse when product is updated
- product  output  2*WIDTH  registered result. Holds its value until the next completion.

Behaviour:
- Interface: one clock (clk). Reset is synchronous, active-high (rst).
- Reset: on a clk edge with rst=1, the following all go to 0:
  - state goes to IDLE
  - busy=0, done=0, product=0
  - internal M, ACC, Q, C and count cleared
- rst overrides all other inputs, including mid-RUN. The in-flight operation is discarded and product reads 0.
- State IDLE:
  - busy=0, done=0.
  - If start=1: capture M<=a, Q<=b, ACC<=0, C<=0, count<=0, then go to RUN.
- State RUN (busy=1), one iteration per cycle:
  - Add step: {C,ACC}' = Q[0] ? ACC + M (WIDTH+1-bit result, ripple-carry) : {1'b0,ACC}.
  - Shift step: {C,ACC,Q} <= ({C,ACC}',Q) >> 1, i.e. ACC <= {C',ACC'[WIDTH-1:1]} and Q <= {ACC'[0],Q[WIDTH-1:1]}.
  - count <= count+1.
  - After the iteration where count==WIDTH-1: product <= {new ACC, new Q}, go to DONE.
- State DONE:
  - done=1 for exactly this cycle, busy=0.
  - If start=1: accept a new operation exactly as in IDLE and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- start while busy=1 is ignored. It is not queued, and a/b changes have no effect.
- Latency: start sampled high at edge k -> busy high for cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1 with the new product visible that same cycle.
- Throughput: one multiply every WIDTH+1 cycles when back-to-back.
- product is never updated with partial values. It changes only on entry to DONE and on reset.
- Arithmetic is unsigned. The full 2*WIDTH result is exact with no overflow. The carry-out of each add must be retained, never dropped.
- Boundaries:
  - a=0 or b=0 yields 0.
  - a=b=2^WIDTH-1 yields (2^WIDTH-1)^2; carry-out occurs on most iterations.
  - count never exceeds WIDTH-1 in RUN.

Test Plan:
- Reset, then a=13, b=11, start pulsed at edge 0:
  - busy=1 cycles 1..8
  - done=1 only in cycle 9 with product=16'h008F (143)
  - product=0 before cycle 9
- a=8'hFF, b=8'hFF -> product=16'hFE01 (65025). Confirms carry-out retention.
- a=8'h00, b=8'hA5 -> 0; then a=8'h5A, b=8'h00 -> 0. In both cases done pulses after exactly 9 cycles.
- Start 7*6. Hold start=1 with a=200, b=200 throughout RUN:
  - result is 42 (16'h002A)
  - since start is still high in the DONE cycle, the second op (40000=16'h9C40) starts back-to-back and completes 9 cycles later
- Start 100*3. Assert rst in cycle 4 of RUN:
  - next cycle busy=0, done=0, product=0
  - no done pulse follows
  - a subsequent 2*3 returns 6
- Over 256 random (a,b) pairs, compare against a*b. Check that product holds between done pulses and that done is never high for two consecutive cycles unless a back-to-back start occurred.

Source files
------------

// File: rtl/seq_mul8.sv
// Multi-cycle unsigned shift-add multiplier: one ripple-carry add and right shift per cycle,
// with a start/busy/done handshake and a product register that updates only on completion.
module seq_mul8 #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     m_q;
   logic [WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]     q_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   product_q;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic                 carry;
   logic [WIDTH-1:0]     acc_d;
   logic [WIDTH-1:0]     q_d;

   // Ripple-carry add of M into ACC when the current multiplier LSB is set.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      addend = q_q[0] ? m_q : '0;
      sum    = '0;
      carry  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = acc_q[i] ^ addend[i] ^ carry;
         carry  = (acc_q[i] & addend[i]) | (carry & (acc_q[i] ^ addend[i]));
      end
      // The carry-out becomes the new ACC MSB; the sum LSB moves into Q.
      acc_d = {carry, sum[WIDTH-1:1]};
      q_d   = {sum[0], q_q[WIDTH-1:1]};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  m_q     <= a;
                  q_q     <= b;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  product_q <= {acc_d, q_d};
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_mul8.sv
// Self-checking bench for seq_mul8: directed handshake/boundary steps, then random operands
// compared against plain a*b with fixed 9-cycle completion latency.
module tb_seq_mul8;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] prev_prod;

   seq_mul8 #(.WIDTH(8), .CNT_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue inputs right after a falling edge so the next rising edge samples them.
   task automatic issue(input logic [7:0] ra, input logic [7:0] rb);
      a     = ra;
      b     = rb;
      start = 1'b1;
   endtask

   // Entered in the first cycle after the accepting edge; leaves the bench in the done cycle.
   task automatic expect_op(input logic [15:0] expv, input string tag);
      for (int i = 1; i <= 8; i++) begin
         check({tag, " busy"}, 32'(busy), 32'd1);
         check({tag, " done_early"}, 32'(done), 32'd0);
         check({tag, " prod_hold"}, 32'(product), 32'(prev_prod));
         @(negedge clk);
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy_end"}, 32'(busy), 32'd0);
      check({tag, " product"}, 32'(product), 32'(expv));
      prev_prod = expv;
   endtask

   // Random-phase monitor: product holds between done pulses, done never two cycles running.
   logic        mon_en = 1'b0;
   logic [15:0] held;
   logic        last_done = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (done) check("double_done", 32'(last_done), 32'd0);
         else      check("hold_between", 32'(product), 32'(held));
      end
      if (done || !mon_en) held = product;
      last_done = done;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  ra, rb;
      logic [15:0] expv;
      int          cyc;
      int          gap;

      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      prev_prod = '0;
      repeat (2) @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst product", 32'(product), 32'd0);
      rst = 1'b0;

      // 13*11 with full per-cycle latency checks
      @(negedge clk);
      issue(8'd13, 8'd11);
      @(negedge clk); start = 1'b0;
      expect_op(16'h008F, "13x11");
      @(negedge clk);
      check("13x11 done_once", 32'(done), 32'd0);

      // All-ones operands exercise carry-out on most iterations
      issue(8'hFF, 8'hFF);
      @(negedge clk); start = 1'b0;
      expect_op(16'hFE01, "ffxff");

      @(negedge clk);
      issue(8'h00, 8'hA5);
      @(negedge clk); start = 1'b0;
      expect_op(16'h0000, "0xa5");
      @(negedge clk);
      issue(8'h5A, 8'h00);
      @(negedge clk); start = 1'b0;
      expect_op(16'h0000, "5ax0");

      // 7*6 with start held high and operands changed during RUN -> back-to-back 200*200
      @(negedge clk);
      issue(8'd7, 8'd6);
      @(negedge clk);
      a = 8'd200; b = 8'd200;
      expect_op(16'h002A, "7x6");
      @(negedge clk); start = 1'b0;
      expect_op(16'h9C40, "200x200");
      @(negedge clk);
      check("b2b idle done", 32'(done), 32'd0);
      check("b2b idle busy", 32'(busy), 32'd0);

      // 100*3 aborted by reset in RUN cycle 4
      issue(8'd100, 8'd3);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort product", 32'(product), 32'd0);
      prev_prod = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort no_done", 32'(done), 32'd0);
      end
      issue(8'd2, 8'd3);
      @(negedge clk); start = 1'b0;
      expect_op(16'd6, "2x3");

      // Random operands, random idle gaps (gap 0 issues from the done cycle: back-to-back)
      mon_en = 1'b1;
      for (int n = 0; n < 256; n++) begin
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         ra = 8'($urandom);
         rb = 8'($urandom);
         expv = {8'h00, ra} * {8'h00, rb};
         issue(ra, rb);
         @(negedge clk); start = 1'b0;
         cyc = 1;
         while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         check("rand latency", 32'(cyc), 32'd9);
         check("rand product", 32'(product), 32'(expv));
      end
      @(negedge clk);
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
